// File: rtl/tcam_ram_param.sv
// RAM-based ternary match engine: per-sub-key bit-vector RAMs ANDed and priority-encoded.
// Optional macro TCAM_PRIO_ENC_EN builds the hit_idx priority encoder; otherwise hit_idx is 0.
module tcam_ram_param #(
    parameter int KEY_W   = 8,
    parameter int SUB_W   = 4,
    parameter int N_RULES = 8,
    parameter int IDX_W   = $clog2(N_RULES)
) (
    input  logic               write_clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic               wr_del,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [KEY_W-1:0]   wr_value,
    input  logic [KEY_W-1:0]   wr_mask,
    input  logic               lk_valid,
    output logic               lk_ready,
    input  logic [KEY_W-1:0]   key,
    output logic               out_valid,
    output logic [N_RULES-1:0] match,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx
);
    localparam int D  = 1 << SUB_W;
    localparam int NB = KEY_W / SUB_W;

    // state    | meaning
    // S_CLEAR  | zeroing RAM address cnt in every block
    // S_IDLE   | accepting updates and lookups
    // S_UPDATE | rewriting bit upd_idx at address cnt in every block
    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_UPDATE} state_t;

    state_t             state_q, state_d;
    logic [SUB_W-1:0]   cnt_q, cnt_d;
    logic               wr_acc, lk_acc;
    logic               upd_del;
    logic [IDX_W-1:0]   upd_idx;
    logic [KEY_W-1:0]   upd_value, upd_mask;
    logic               idx_ok;
    logic [NB-1:0]      upd_bit;
    logic [N_RULES-1:0] mem [NB][D];
    logic               lk_v0, lk_v1;
    logic [KEY_W-1:0]   key_q;
    logic [N_RULES-1:0] rd_vec [NB];
    logic [N_RULES-1:0] and_vec;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ready = 1'b0;
        lk_ready = 1'b0;
        case (state_q)
            S_CLEAR, S_UPDATE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                wr_ready = 1'b1;
                lk_ready = 1'b1;
                if (wr_valid) begin
                    state_d = S_UPDATE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    assign wr_acc = wr_valid & wr_ready;
    assign lk_acc = lk_valid & lk_ready;

    always_ff @(posedge write_clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            cnt_q     <= '0;
            upd_del   <= 1'b0;
            upd_idx   <= '0;
            upd_value <= '0;
            upd_mask  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (wr_acc) begin
                upd_del   <= wr_del;
                upd_idx   <= wr_idx;
                upd_value <= wr_value;
                upd_mask  <= wr_mask;
            end
        end
    end

    // Out-of-range indices are accepted but must not touch any RAM bit.
    assign idx_ok = int'(upd_idx) < N_RULES;

    always_comb begin
        upd_bit = '0;
        for (int b = 0; b < NB; b++)
            upd_bit[b] = !upd_del &&
                (((cnt_q ^ upd_value[b*SUB_W +: SUB_W]) & upd_mask[b*SUB_W +: SUB_W]) == '0);
    end

    always_ff @(posedge write_clk) begin
        for (int b = 0; b < NB; b++) begin
            if (state_q == S_CLEAR)
                mem[b][cnt_q] <= '0;
            else if (state_q == S_UPDATE && idx_ok)
                mem[b][cnt_q][upd_idx] <= upd_bit[b];
        end
    end

    // Read happens one edge after acceptance, before that edge's update write lands.
    always_ff @(posedge write_clk) begin
        if (lk_acc) key_q <= key;
        if (lk_v0)
            for (int b = 0; b < NB; b++)
                rd_vec[b] <= mem[b][key_q[b*SUB_W +: SUB_W]];
    end

    always_comb begin
        and_vec = '1;
        for (int b = 0; b < NB; b++)
            and_vec = and_vec & rd_vec[b];
    end

    always_ff @(posedge write_clk) begin
        if (rst) begin
            lk_v0     <= 1'b0;
            lk_v1     <= 1'b0;
            out_valid <= 1'b0;
            match     <= '0;
            hit       <= 1'b0;
        end else begin
            lk_v0     <= lk_acc;
            lk_v1     <= lk_v0;
            out_valid <= lk_v1;
            if (lk_v1) begin
                match <= and_vec;
                hit   <= |and_vec;
            end
        end
    end

`ifdef TCAM_PRIO_ENC_EN
    logic [IDX_W-1:0] enc;

    always_comb begin
        enc = '0;
        for (int r = N_RULES - 1; r >= 0; r--)
            if (and_vec[r]) enc = IDX_W'(r);
    end

    always_ff @(posedge write_clk) begin
        if (rst)
            hit_idx <= '0;
        else if (lk_v1)
            hit_idx <= enc;
    end
`else
    assign hit_idx = '0;
`endif

endmodule

// File: tb/tb_tcam_ram_param.sv
// Directed self-checking bench for tcam_ram_param at default parameters (D=16, NB=2).
module tb_tcam_ram_param;
    logic       write_clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       wr_del = 1'b0;
    logic [2:0] wr_idx = '0;
    logic [7:0] wr_value = '0;
    logic [7:0] wr_mask = '0;
    logic       lk_valid = 1'b0;
    logic       lk_ready;
    logic [7:0] key = '0;
    logic       out_valid;
    logic [7:0] match;
    logic       hit;
    logic [2:0] hit_idx;

    int n_tests = 0;
    int n_fail  = 0;

    tcam_ram_param dut (
        .write_clk(write_clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_del(wr_del),
        .wr_idx(wr_idx), .wr_value(wr_value), .wr_mask(wr_mask),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .key(key),
        .out_valid(out_valid), .match(match), .hit(hit), .hit_idx(hit_idx)
    );

    always #5 write_clk = ~write_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ei(input int i);
`ifdef TCAM_PRIO_ENC_EN
        return i;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        tick();
        chk({tag, "_rst_ov"}, 32'(out_valid), 0);
        chk({tag, "_rst_match"}, 32'(match), 0);
        chk({tag, "_rst_hit"}, 32'(hit), 0);
        chk({tag, "_rst_idx"}, 32'(hit_idx), 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_clear_rdy"}, {30'd0, wr_ready, lk_ready}, 0);
            tick();
        end
        chk({tag, "_rdy_up"}, {30'd0, wr_ready, lk_ready}, 3);
    endtask

    task automatic lookup(input string tag, input logic [7:0] k,
                          input logic [7:0] exp_m, input int exp_i);
        lk_valid = 1'b1;
        key = k;
        tick();
        lk_valid = 1'b0;
        chk({tag, "_ov_t0"}, 32'(out_valid), 0);
        tick();
        chk({tag, "_ov_t1"}, 32'(out_valid), 0);
        tick();
        chk({tag, "_ov"}, 32'(out_valid), 1);
        chk({tag, "_match"}, 32'(match), 32'(exp_m));
        chk({tag, "_hit"}, 32'(hit), 32'(exp_m != 0));
        chk({tag, "_idx"}, 32'(hit_idx), ei(exp_i));
        tick();
        chk({tag, "_ov_off"}, 32'(out_valid), 0);
        chk({tag, "_hold"}, 32'(match), 32'(exp_m));
    endtask

    task automatic write_rule(input string tag, input logic del, input logic [2:0] idx,
                              input logic [7:0] val, input logic [7:0] msk);
        int n, lo;
        wr_valid = 1'b1;
        wr_del = del;
        wr_idx = idx;
        wr_value = val;
        wr_mask = msk;
        tick();
        wr_valid = 1'b0;
        n = 0;
        lo = 0;
        while (!wr_ready && n < 40) begin
            n++;
            if (!lk_ready) lo++;
            tick();
        end
        chk({tag, "_wr_busy"}, 32'(n), 16);
        chk({tag, "_lk_busy"}, 32'(lo), 16);
    endtask

    initial begin
        int lo;
        do_reset("boot");
        lookup("empty", 8'h00, 8'h00, 0);

        write_rule("ins2", 1'b0, 3'd2, 8'hA5, 8'hFF);
        lookup("a5_r2", 8'hA5, 8'h04, 2);
        lookup("a4_miss", 8'hA4, 8'h00, 0);

        write_rule("ins5", 1'b0, 3'd5, 8'hA0, 8'hF0);
        lookup("a7_r5", 8'hA7, 8'h20, 5);
        lookup("a5_r25", 8'hA5, 8'h24, 2);

        lk_valid = 1'b1;
        key = 8'hA7;
        tick();
        key = 8'hA5;
        tick();
        lk_valid = 1'b0;
        chk("b2b_ov_t1", 32'(out_valid), 0);
        tick();
        chk("b2b_ov_a", 32'(out_valid), 1);
        chk("b2b_match_a", 32'(match), 32'h20);
        chk("b2b_idx_a", 32'(hit_idx), ei(5));
        tick();
        chk("b2b_ov_b", 32'(out_valid), 1);
        chk("b2b_match_b", 32'(match), 32'h24);
        chk("b2b_idx_b", 32'(hit_idx), ei(2));
        tick();
        chk("b2b_ov_off", 32'(out_valid), 0);

        write_rule("del2", 1'b1, 3'd2, 8'h00, 8'h00);
        lookup("a5_after_del", 8'hA5, 8'h20, 5);

        write_rule("reins2", 1'b0, 3'd2, 8'hA5, 8'hFF);
        lookup("a5_reins", 8'hA5, 8'h24, 2);

        wr_valid = 1'b1;
        wr_del = 1'b1;
        wr_idx = 3'd2;
        lk_valid = 1'b1;
        key = 8'hA5;
        tick();
        wr_valid = 1'b0;
        lk_valid = 1'b0;
        lo = 0;
        for (int i = 0; i < 20; i++) begin
            if (!lk_ready) lo++;
            if (i == 2) begin
                chk("simul_ov", 32'(out_valid), 1);
                chk("simul_match", 32'(match), 32'h24);
                chk("simul_idx", 32'(hit_idx), ei(2));
            end
            tick();
        end
        chk("simul_lk_busy", 32'(lo), 16);
        lookup("a5_simul_after", 8'hA5, 8'h20, 5);

        wr_valid = 1'b1;
        wr_del = 1'b0;
        wr_idx = 3'd3;
        wr_value = 8'hA7;
        wr_mask = 8'hFF;
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_upd_busy", {30'd0, wr_ready, lk_ready}, 0);
        do_reset("midrst");
        lookup("a7_after_rst", 8'hA7, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tcam_ram_param.md
# tcam_ram_param

Parametrised RAM-based ternary match engine, the next generation of the 8-bit RAM-based TCAM. The key is split into `KEY_W/SUB_W` sub-keys, and each sub-key addresses its own `2^SUB_W x N_RULES` bit-vector RAM. A lookup ANDs the per-block vectors and priority-encodes the result. Rules are programmed as (value, mask) pairs by an internal update FSM that expands each rule across all sub-key addresses, so software never computes row data. The block sits between the rule-management interface and the packet-classification datapath.

## Interface
Parameters:
- `KEY_W`, default 8: key width in bits; must be a multiple of `SUB_W`.
- `SUB_W`, default 4: sub-key width. RAM depth is `D = 2^SUB_W` and the block count is `NB = KEY_W/SUB_W`.
- `N_RULES`, default 8: number of rules; this is the match-vector width.
- `IDX_W`, default `$clog2(N_RULES)`: rule index width.

Ports:
- `write_clk`, in, 1: the single clock. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `wr_valid`, in, 1: rule update request.
- `wr_ready`, out, 1: update accepted when `wr_valid & wr_ready`.
- `wr_del`, in, 1: 1 deletes the rule, 0 installs it.
- `wr_idx`, in, `IDX_W`: rule index to update.
- `wr_value`, in, `KEY_W`: rule value.
- `wr_mask`, in, `KEY_W`: care mask. A 1 bit must match; a 0 bit is don't-care.
- `lk_valid`, in, 1: lookup request.
- `lk_ready`, out, 1: lookup accepted when `lk_valid & lk_ready`.
- `key`, in, `KEY_W`: lookup key.
- `out_valid`, out, 1: one-cycle result strobe.
- `match`, out, `N_RULES`: bit r is set if rule r matches.
- `hit`, out, 1: OR-reduction of `match`.
- `hit_idx`, out, `IDX_W`: lowest matching rule index.

## Operation
FSM states are CLEAR, IDLE and UPDATE. A `SUB_W`-bit counter `cnt` walks the RAM addresses.

CLEAR:
- Entered on `rst`.
- Writes all-zero to address `cnt` of every block, for `cnt` = 0..D-1.
- Moves to IDLE after address D-1.

IDLE:
- `wr_ready` and `lk_ready` are both 1.
- An accepted write latches `wr_idx`, `wr_value`, `wr_mask` and `wr_del`, clears `cnt` and moves to UPDATE.

UPDATE:
- Runs for D cycles. In each cycle, every block b performs a read-modify-write of bit `wr_idx` at address `cnt`.
- Bit value is 0 if deleting. Otherwise it is `((cnt ^ value_b) & mask_b) == 0`, where `value_b` and `mask_b` are bits `[b*SUB_W +: SUB_W]` of the latched value and mask.
- Moves to IDLE after `cnt == D-1`.
- All other rule bits are preserved.

Lookup:
- Stage 1 reads every block at its sub-key.
- Stage 2 registers the AND of the NB vectors into `match`, and computes `hit` and `hit_idx`.
- Lookups are independent of `wr_idx`.
- `wr_idx >= N_RULES` is accepted and has no effect on any RAM bit.

## Timing
- Reset values: `wr_ready`=0, `lk_ready`=0, `out_valid`=0, `match`=0, `hit`=0, `hit_idx`=0.
- After `rst` deasserts, CLEAR lasts D cycles. Both readies rise in cycle D+1.
- A reset asserted mid-update or mid-lookup aborts it. Any in-flight `out_valid` is dropped, and CLEAR restarts from address 0.
- Lookup latency: if accepted at edge T, `out_valid` is 1 for exactly the cycle after edge T+2.
- Throughput is one lookup per cycle in IDLE.
- Update: if accepted at edge T, the RAM is written at edges T+1..T+D and `wr_ready` is 1 again after edge T+D. Both readies are 0 during UPDATE.
- Simultaneous write and lookup accepted in the same IDLE cycle: the lookup sees the pre-update contents.
- A lookup accepted before an update completes its stage 2 unaffected.
- `match`, `hit` and `hit_idx` hold their values between strobes.

## Configuration
- `TCAM_PRIO_ENC_EN` defined: `hit_idx` is the lowest set bit of `match`, registered with `match`.
- `TCAM_PRIO_ENC_EN` undefined: no priority encoder is built. `hit_idx` is tied to 0, and `match`, `hit` and the latency are unchanged.

## Test plan
All scenarios use defaults: D=16, NB=2.
- Reset, then hold: `wr_ready`/`lk_ready` stay 0 for 16 cycles and go 1 in cycle 17. Lookup key 8'h00 then gives `match`=0 and `hit`=0.
- Install rule 2 with value 8'hA5, mask 8'hFF. Lookup 8'hA5 gives `match`=8'h04, `hit`=1, `hit_idx`=2. Lookup 8'hA4 gives `match`=0.
- Then install rule 5 with value 8'hA0, mask 8'hF0. Lookup 8'hA7 gives 8'h20 with idx 5. Lookup 8'hA5 gives 8'h24 with idx 2. Back-to-back lookups produce consecutive `out_valid` pulses exactly 2 cycles after acceptance.
- Delete rule 2. `wr_ready` is low for 16 cycles. Lookup 8'hA5 then gives 8'h20 with idx 5.
- Write and lookup of 8'hA5 accepted in the same cycle while rule 2 is being deleted: the lookup returns the old 8'h24. `lk_ready`=0 for the next 16 cycles.
- Assert `rst` at the 8th cycle of an UPDATE: full CLEAR runs, and a subsequent lookup of 8'hA7 returns 0. With the macro undefined, `hit_idx` is 0 in every scenario.
